// File: rtl/weight_dot_engine_if.sv
// Read port shared by the dot-product engine, the weight memory and the feature buffer.
// Both memories see the same address/enable and answer with one cycle of latency.
interface weight_dot_engine_if #(
  parameter int AW = 5,
  parameter int WW = 9,
  parameter int FW = 9
) ();
  logic [AW-1:0]        mem_addr;
  logic                 mem_read;
  logic signed [WW-1:0] mem_dout;
  logic signed [FW-1:0] feat_dout;

  modport master (output mem_addr, output mem_read, input mem_dout, input feat_dout);
  modport slave  (input mem_addr, input mem_read, output mem_dout, output feat_dout);
endinterface

// File: rtl/weight_dot_engine.sv
// Sweeps the weight memory and feature buffer, accumulating one signed dot product per start.
// Optional feature macro: WEIGHT_DOT_BIAS_EN adds a bias port that preloads the accumulator.
module weight_dot_engine #(
  parameter int N_WEIGHTS = 30,
  parameter int AW        = 5,
  parameter int WW        = 9,
  parameter int FW        = 9,
  parameter int ACCW      = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
`ifdef WEIGHT_DOT_BIAS_EN
  input  logic signed [ACCW-1:0] bias,
`endif
  weight_dot_engine_if.master    mem,
  output logic                   busy,
  output logic signed [ACCW-1:0] result,
  output logic                   result_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [AW-1:0]           cnt;
  logic                    rd_pend;
  logic                    last_addr;
  logic signed [ACCW-1:0]  acc;
  logic signed [ACCW-1:0]  acc_sum;
  logic signed [ACCW-1:0]  preload;
  logic signed [WW+FW-1:0] prod;

`ifdef WEIGHT_DOT_BIAS_EN
  assign preload = bias;
`else
  assign preload = '0;
`endif

  assign last_addr = (cnt == AW'(N_WEIGHTS - 1));
  assign busy      = (state != IDLE);

  // Full-width signed product, sign-extended before the wrapping accumulate.
  assign prod    = (WW+FW)'(mem.mem_dout) * (WW+FW)'(mem.feat_dout);
  assign acc_sum = acc + ACCW'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mem.mem_read = 1'b0;
    mem.mem_addr = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        mem.mem_read = 1'b1;
        mem.mem_addr = cnt;
        if (last_addr) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
    end
  end

  // Data returned for a read lands one cycle later, so rd_pend gates the accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      rd_pend      <= 1'b0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      rd_pend      <= mem.mem_read & ~abort;
      result_valid <= (state == DRAIN) & ~abort;

      if (state == FETCH && state_nxt == FETCH) begin
        cnt <= cnt + AW'(1);
      end else begin
        cnt <= '0;
      end

      if (state == IDLE) begin
        acc <= preload;
      end else if (rd_pend) begin
        acc <= acc_sum;
      end

      if (state == DRAIN && !abort) begin
        result <= rd_pend ? acc_sum : acc;
      end
    end
  end

endmodule

// File: doc/weight_dot_engine.md
# weight_dot_engine

Sequencer and multiply-accumulate stage directly downstream of the weight memory. On `start` it sweeps addresses 0..N_WEIGHTS-1 with `mem_read` asserted and consumes the 1-cycle-latency 9-bit signed weight read data. The same address indexes the feature buffer in lock-step. It accumulates the signed products of weights and features into one dot-product result, which it presents with a single-cycle valid pulse.

## Interface
- `N_WEIGHTS`, 30, number of weight/feature pairs per dot product (≥2)
- `AW`, 5, address width; must satisfy 2^AW > N_WEIGHTS
- `WW`, 9, weight width (signed)
- `FW`, 9, feature width (signed)
- `ACCW`, 24, accumulator/result width (signed)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request one dot product; honoured only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE
- `mem_addr`  out  AW  address to weight memory and feature buffer
- `mem_read`  out  1  read enable to weight memory and feature buffer
- `mem_dout`  in  WW  weight read data, valid one cycle after `mem_read`
- `feat_dout`  in  FW  feature read data, same latency as `mem_dout`
- `busy`  out  1  high in any state other than IDLE
- `result`  out  ACCW  signed dot product; held until the next DONE
- `result_valid`  out  1  one-cycle pulse when `result` updates

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - `start`=1 → FETCH.
  - Accumulator is loaded with 0 (or bias, see Configuration).
  - Address counter is cleared to 0.
- FETCH:
  - `mem_read`=1, `mem_addr`=counter; counter increments each cycle.
  - A 1-bit `rd_pend` register captures `mem_read`.
  - The counter never reaches N_WEIGHTS, so address 30 is never issued.
  - After address N_WEIGHTS-1 is issued → DRAIN.
- DRAIN: `mem_read`=0; last read data is accumulated; → DONE.
- DONE:
  - `result` ← accumulator; `result_valid`=1; → IDLE.
- Accumulate rule:
  - Whenever `rd_pend`=1, `acc ← acc + sext(mem_dout × feat_dout)`.
  - The product is a full WW+FW signed value (18 bits), sign-extended to ACCW.
  - Wrap-around (no saturation) on ACCW overflow. The default 24 bits cannot overflow for 30 full-scale 9×9 products (max |sum| 1,966,080).
- `start` outside IDLE is ignored. This includes the DONE cycle; no queueing.
- `abort`=1 in any state:
  - Next state is IDLE; `mem_read` drops the next cycle; `rd_pend` is cleared.
  - `result` is unchanged and no `result_valid` is generated.
  - `abort` has priority over `start`.
- Outputs in IDLE: `mem_addr`=0, `mem_read`=0.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycle k+1 (k=0..N_WEIGHTS-1): `mem_addr`=k, `mem_read`=1.
- Cycle k+2: data k is presented and accumulated at the end of that cycle.
- Cycle N_WEIGHTS+1: DRAIN.
- Cycle N_WEIGHTS+2: DONE, `result_valid`=1 (cycle 32 for default N).
- Cycle N_WEIGHTS+3: IDLE; the earliest next `start` is sampled here.
- Throughput: one dot product per N_WEIGHTS+3 cycles.
- Reset (async, any time) sets:
  - state IDLE, counter 0, `rd_pend` 0, accumulator 0;
  - `result`=0, `result_valid`=0, `busy`=0, `mem_addr`=0, `mem_read`=0.
- Deasserting reset mid-operation restarts cleanly from IDLE.

## Configuration
- `WEIGHT_DOT_BIAS_EN` defined:
  - Adds input port `bias` (ACCW, signed).
  - `bias` is sampled in the `start`-accepted cycle and preloads the accumulator.
- `WEIGHT_DOT_BIAS_EN` undefined:
  - No `bias` port; the accumulator preloads 0.
  - All other behaviour is identical.

## Test plan
- All weights 1, features 1..30, `start` at cycle 0 → `result`=465 with `result_valid` at cycle 32; `mem_addr` sequence 0..29 on cycles 1..30.
- All weights -256, features 255 → `result`=-1958400; check sign extension.
- Weights alternate +255/-256, features all -256 → `result`=3840; check the sign handling of the mixed-sign products.
- `start` held high continuously → results at cycles 32, 65, 98; `start` during FETCH/DRAIN/DONE has no effect.
- `abort` at cycle 10 → IDLE at cycle 11, `mem_read`=0, no `result_valid`, prior `result` kept. `rst_n` low at cycle 15 of a later run → all outputs 0 immediately.
- With `WEIGHT_DOT_BIAS_EN`, first scenario with `bias`=-465 → `result`=0; `bias`=1000 → 1465.
